// File: rtl/mips_dmem_responder_pkg.sv
// Shared types and constants for the wait-stated MIPS data-memory responder.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] DMEM_BASE_DEF = 32'h0000_2000;
  localparam logic [31:0] MMIO_ADDR_DEF = 32'hFFFF_0000;
  localparam int unsigned WORD_BYTES    = 4;

  // Unsigned 32-bit offset from base, in words; below-base addresses produce huge indices.
  function automatic logic [31:0] addr_to_index(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) >> $clog2(WORD_BYTES);
  endfunction

endpackage

// File: rtl/mips_dmem_responder_if.sv
// CPU data-port bundle between mips_cpu_adv (master) and the memory responder (slave).
interface mips_dmem_responder_if;
  logic [31:0] data_addr;
  logic [31:0] data_in;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] data_out;
  logic        mem_ready;
  logic        mem_err;

  modport master (
    output data_addr, data_in, mem_read, mem_write,
    input  data_out, mem_ready, mem_err
  );

  modport slave (
    input  data_addr, data_in, mem_read, mem_write,
    output data_out, mem_ready, mem_err
  );
endinterface

// File: rtl/mips_dmem_responder_sram.sv
// Single-port synchronous word RAM with write enable and registered read.
module mips_dmem_sram #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mips_dmem_responder.sv
// Wait-stated data-memory responder for the MIPS CPU data port.
// Optional cycle-counter MMIO register enabled by `define MIPS_DMEM_MMIO_EN.
module mips_dmem_responder
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE   = DMEM_BASE_DEF,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] MMIO_ADDR   = MMIO_ADDR_DEF
) (
  input logic                 clk,
  input logic                 rst,
  mips_dmem_responder_if.slave bus
);

  state_t                state;
  logic [3:0]            cnt;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic                  rd_q;
  logic                  err_q;

  logic [31:0]           idx_full;
  logic                  in_range;
  logic                  region_ok;
  logic                  acc_err;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic                  ram_we;
  logic [31:0]           ram_rdata;

`ifdef MIPS_DMEM_MMIO_EN
  logic        is_mmio;
  logic        mmio_q;
  logic [31:0] cyc_cnt;
`endif

  always_comb begin
    idx_full  = addr_to_index(bus.data_addr, DMEM_BASE);
    in_range  = (bus.data_addr >= DMEM_BASE) && (idx_full < (32'd1 << DEPTH_LOG2));
    region_ok = in_range;
`ifdef MIPS_DMEM_MMIO_EN
    is_mmio   = (bus.data_addr == MMIO_ADDR);
    region_ok = in_range | is_mmio;
`endif
    acc_err   = (bus.mem_read & bus.mem_write) | (bus.data_addr[1:0] != 2'b00) | !region_ok;
  end

  // In IDLE the RAM is addressed straight from the bus so the registered read
  // is already valid by the end of RESP even when WAIT_STATES is 0.
  always_comb begin
    ram_addr = (state == IDLE) ? idx_full[DEPTH_LOG2-1:0] : idx_q;
    ram_we   = !rst && (state == RESP) && !rd_q && !err_q;
`ifdef MIPS_DMEM_MMIO_EN
    ram_we   = ram_we && !mmio_q;
`endif
  end

  mips_dmem_sram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_sram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      idx_q         <= '0;
      wdata_q       <= '0;
      rd_q          <= 1'b0;
      err_q         <= 1'b0;
      bus.data_out  <= '0;
      bus.mem_ready <= 1'b0;
      bus.mem_err   <= 1'b0;
`ifdef MIPS_DMEM_MMIO_EN
      mmio_q        <= 1'b0;
`endif
    end else begin
      bus.mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mem_read | bus.mem_write) begin
            idx_q   <= idx_full[DEPTH_LOG2-1:0];
            wdata_q <= bus.data_in;
            rd_q    <= bus.mem_read;
            err_q   <= acc_err;
`ifdef MIPS_DMEM_MMIO_EN
            mmio_q  <= is_mmio;
`endif
            cnt     <= 4'(WAIT_STATES);
            if (WAIT_STATES > 0) begin
              state <= WAIT;
            end else begin
              state         <= RESP;
              bus.mem_ready <= 1'b1;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state         <= RESP;
            bus.mem_ready <= 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          if (err_q) begin
            bus.mem_err <= 1'b1;
            if (rd_q) bus.data_out <= '0;
          end
`ifdef MIPS_DMEM_MMIO_EN
          else if (mmio_q) begin
            // Return the value the counter takes at this edge, i.e. cycles since last clear.
            if (rd_q) bus.data_out <= cyc_cnt + 32'd1;
          end
`endif
          else if (rd_q) begin
            bus.data_out <= ram_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MIPS_DMEM_MMIO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt <= '0;
    end else if ((state == RESP) && mmio_q && !err_q && !rd_q) begin
      cyc_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Directed self-checking bench for mips_dmem_responder (default WAIT_STATES=2).
module tb_mips_dmem_responder;
  import mips_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  longint cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;

  localparam int WS = 2;

  mips_dmem_responder_if bus ();

  mips_dmem_responder #(
    .DMEM_BASE  (32'h0000_2000),
    .DEPTH_LOG2 (10),
    .WAIT_STATES(WS),
    .MMIO_ADDR  (32'hFFFF_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Issues one single-cycle request and reports latency (edges after accept until
  // mem_ready is seen), whether the pulse lasted exactly one cycle, and the RESP edge index.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat, output bit pulse_ok,
                           output longint resp_cyc);
    bit seen;
    lat = 0; seen = 0; pulse_ok = 0; resp_cyc = -1;
    @(negedge clk);
    bus.data_addr = addr; bus.data_in = wdata; bus.mem_read = rd; bus.mem_write = wr;
    @(posedge clk);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      bus.mem_read = 1'b0; bus.mem_write = 1'b0;
      if (bus.mem_ready) seen = 1;
      else begin @(posedge clk); lat++; end
    end
    if (!seen) lat = -1;
    else begin
      @(posedge clk);
      resp_cyc = cyc;
      @(negedge clk);
      pulse_ok = (bus.mem_ready === 1'b0);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1'b1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(posedge clk); @(negedge clk);
    tests_run++;
    if (bus.data_out !== 32'h0 || bus.mem_ready !== 1'b0 || bus.mem_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: data_out=%h ready=%b err=%b, want 0/0/0",
               bus.data_out, bus.mem_ready, bus.mem_err);
    end
    tests_run++;
    if (dut.state !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: state=%0d, want IDLE", dut.state);
    end
  endtask

  task automatic test_write_read();
    int lat; bit pok; longint rc;
    do_access(1'b0, 1'b1, 32'h2004, 32'hDEADBEEF, lat, pok, rc);
    tests_run++;
    if (lat != WS || !pok || bus.mem_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_latency: lat=%0d pulse_ok=%0b err=%b, want %0d/1/0", lat, pok, bus.mem_err, WS);
    end
    do_access(1'b1, 1'b0, 32'h2004, 32'h0, lat, pok, rc);
    tests_run++;
    if (lat != WS || !pok || bus.data_out !== 32'hDEADBEEF || bus.mem_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_2004: lat=%0d pulse_ok=%0b data=%h err=%b, want %0d/1/deadbeef/0",
               lat, pok, bus.data_out, bus.mem_err, WS);
    end
    do_access(1'b0, 1'b1, 32'h2008, 32'h0000_0011, lat, pok, rc);
    do_access(1'b0, 1'b1, 32'h200C, 32'hA5A5_0F0F, lat, pok, rc);
    // last in-range word
    do_access(1'b0, 1'b1, 32'h2FFC, 32'h1234_5678, lat, pok, rc);
    do_access(1'b1, 1'b0, 32'h2FFC, 32'h0, lat, pok, rc);
    tests_run++;
    if (bus.data_out !== 32'h1234_5678 || bus.mem_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_top_word: data=%h err=%b, want 12345678/0", bus.data_out, bus.mem_err);
    end
    do_access(1'b1, 1'b0, 32'h2008, 32'h0, lat, pok, rc);
    tests_run++;
    if (bus.data_out !== 32'h0000_0011) begin
      tests_failed++;
      $display("FAIL read_2008: data=%h, want 00000011", bus.data_out);
    end
  endtask

  task automatic test_errors();
    int lat; bit pok; longint rc;
    do_access(1'b1, 1'b0, 32'h2002, 32'h0, lat, pok, rc);
    tests_run++;
    if (lat != WS || !pok || bus.data_out !== 32'h0 || bus.mem_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL misaligned: lat=%0d pulse_ok=%0b data=%h err=%b, want %0d/1/0/1",
               lat, pok, bus.data_out, bus.mem_err, WS);
    end
    do_access(1'b1, 1'b0, 32'h2004, 32'h0, lat, pok, rc);
    do_access(1'b1, 1'b0, 32'h1FFC, 32'h0, lat, pok, rc);
    tests_run++;
    if (lat != WS || bus.data_out !== 32'h0 || bus.mem_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL below_base: lat=%0d data=%h err=%b, want %0d/0/1", lat, bus.data_out, bus.mem_err, WS);
    end
    do_access(1'b1, 1'b0, 32'h2004, 32'h0, lat, pok, rc);
    do_access(1'b1, 1'b0, 32'h3000, 32'h0, lat, pok, rc);
    tests_run++;
    if (bus.data_out !== 32'h0 || bus.mem_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL above_top: data=%h err=%b, want 0/1", bus.data_out, bus.mem_err);
    end
    do_access(1'b1, 1'b0, 32'h2004, 32'h0, lat, pok, rc);
    tests_run++;
    if (bus.data_out !== 32'hDEADBEEF || bus.mem_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL read_after_err: data=%h err=%b, want deadbeef/1 (sticky)", bus.data_out, bus.mem_err);
    end
  endtask

  task automatic test_both_ops();
    int lat; bit pok; longint rc;
    apply_reset();
    do_access(1'b1, 1'b1, 32'h2008, 32'h0000_0099, lat, pok, rc);
    tests_run++;
    if (lat != WS || bus.mem_err !== 1'b1 || bus.data_out !== 32'h0) begin
      tests_failed++;
      $display("FAIL rd_wr_both: lat=%0d err=%b data=%h, want %0d/1/0", lat, bus.mem_err, bus.data_out, WS);
    end
    do_access(1'b1, 1'b0, 32'h2008, 32'h0, lat, pok, rc);
    tests_run++;
    if (bus.data_out !== 32'h0000_0011) begin
      tests_failed++;
      $display("FAIL rd_wr_ram_kept: data=%h, want 00000011", bus.data_out);
    end
  endtask

  task automatic test_reset_abort();
    int lat; bit pok; longint rc; bit saw;
    apply_reset();
    saw = 0;
    @(negedge clk);
    bus.data_addr = 32'h200C; bus.data_in = 32'h55; bus.mem_write = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mem_write = 1'b0; rst = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); if (bus.mem_ready) saw = 1; end
    rst = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); if (bus.mem_ready) saw = 1; end
    tests_run++;
    if (saw) begin
      tests_failed++;
      $display("FAIL abort_no_ready: mem_ready seen=1, want 0");
    end
    do_access(1'b1, 1'b0, 32'h200C, 32'h0, lat, pok, rc);
    tests_run++;
    if (bus.data_out !== 32'hA5A5_0F0F || bus.mem_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_ram_kept: data=%h err=%b, want a5a50f0f/0", bus.data_out, bus.mem_err);
    end
  endtask

  task automatic test_back_to_back();
    int first, second;
    first = -1; second = -1;
    @(negedge clk);
    bus.data_addr = 32'h2004; bus.mem_read = 1'b1; bus.mem_write = 1'b0;
    for (int c = 0; c < 30 && second < 0; c++) begin
      @(posedge clk); @(negedge clk);
      if (bus.mem_ready) begin
        if (first < 0) first = c;
        else begin second = c; bus.mem_read = 1'b0; end
      end
    end
    bus.mem_read = 1'b0;
    @(posedge clk); @(negedge clk);
    tests_run++;
    if (first < 0 || second < 0 || (second - first) != WS + 2) begin
      tests_failed++;
      $display("FAIL back_to_back_gap: first=%0d second=%0d gap=%0d, want gap %0d",
               first, second, second - first, WS + 2);
    end
    tests_run++;
    if (bus.data_out !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL back_to_back_data: data=%h, want deadbeef", bus.data_out);
    end
  endtask

  task automatic test_mmio();
    int lat; bit pok; longint e1, e2;
    apply_reset();
`ifdef MIPS_DMEM_MMIO_EN
    do_access(1'b0, 1'b1, 32'hFFFF_0000, 32'h0, lat, pok, e1);
    repeat (10) @(posedge clk);
    do_access(1'b1, 1'b0, 32'hFFFF_0000, 32'h0, lat, pok, e2);
    tests_run++;
    if (e1 < 0 || e2 < 0 || bus.data_out !== 32'(e2 - e1) || bus.mem_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL mmio_counter: data=%0d err=%b, want %0d/0", bus.data_out, bus.mem_err, e2 - e1);
    end
`else
    e1 = 0;
    do_access(1'b1, 1'b0, 32'hFFFF_0000, 32'h0, lat, pok, e2);
    tests_run++;
    if (lat != WS || e2 < e1 || bus.data_out !== 32'h0 || bus.mem_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL mmio_disabled: lat=%0d data=%h err=%b, want %0d/0/1", lat, bus.data_out, bus.mem_err, WS);
    end
`endif
  endtask

  initial begin
    bus.data_addr = '0; bus.data_in = '0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    test_reset();
    test_write_read();
    test_errors();
    test_both_ops();
    test_reset_abort();
    test_back_to_back();
    test_mmio();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
